decode_issue_stage: RTL and testbench

- Registered, parametrised successor to the combinational instruction decoder.
- Accepts raw instructions over a valid/ready handshake and decodes them into one output register.
- Holds issue on register RAW/WAW hazards using a pending-write scoreboard; writeback clears scoreboard entries.
- Sits between fetch and execute; supports pipeline flush.

---
 rtl/decode_pkg.sv | 32 +++
 rtl/reg_scoreboard.sv | 34 +++
 rtl/decode_issue_stage.sv | 141 ++++++++++++++
 tb/tb_decode_issue_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types, field positions and control decode for decode_issue_stage.
package decode_pkg;

   typedef struct packed {
      logic cond_update;
      logic mem_rd;
      logic mem_wr;
      logic reg_wr;
   } ctrl_t;

   localparam int unsigned WSEL_LSB = 8;
   localparam int unsigned ASEL_LSB = 5;
   localparam int unsigned BSEL_LSB = 2;
   localparam int unsigned IMM5_W   = 5;
   localparam int unsigned IMM8_W   = 8;
   localparam int unsigned IMM11_W  = 11;

   // a..e are opcode bits 4..0
   function automatic ctrl_t decode_ctrl(input logic [4:0] op);
      logic  a, b, c, d, e;
      ctrl_t r;
      {a, b, c, d, e} = op;
      r.cond_update = (!b & !d & e) | (!b & !c & !e) | (!a & !c & !d & e) |
                      (!a & b & c & !d & !e);
      r.mem_rd      = !a & c & d & e;
      r.mem_wr      = (!a & !c & d & e) | (a & b & c & d & e);
      r.reg_wr      = (!a & !c & !d) | (!a & b & c) | (!a & d & !e) | (!b & c & d) |
                      (a & !b & !c) | (a & !b & !d & !e);
      return r;
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, issue sets, writeback clears, set wins.
module reg_scoreboard #(
   parameter int unsigned RBITS = 3,
   parameter int unsigned NREGS = 2**RBITS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_set,
   input  logic [RBITS-1:0] i_set_sel,
   input  logic             i_clr,
   input  logic [RBITS-1:0] i_clr_sel,
   output logic [NREGS-1:0] o_pend
);

   logic [NREGS-1:0] r_sb;
   logic [NREGS-1:0] w_set_mask;
   logic [NREGS-1:0] w_clr_mask;

   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      if (i_set) w_set_mask[i_set_sel] = 1'b1;
      if (i_clr) w_clr_mask[i_clr_sel] = 1'b1;
   end

   // Same-cycle writeback already releases the register for hazard checks
   assign o_pend = r_sb & ~w_clr_mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_sb <= '0;
      else     r_sb <= (r_sb & ~w_clr_mask) | w_set_mask;
   end

endmodule

// File: rtl/decode_issue_stage.sv
// Registered decode/issue stage with RAW/WAW hold and flush.
// Optional DECODE_ISSUE_STATS_EN adds stall_cnt / issue_cnt outputs.
module decode_issue_stage
   import decode_pkg::*;
#(
   parameter int unsigned BITS    = 16,
   parameter int unsigned RBITS   = 3,
   parameter int unsigned OP_BITS = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BITS-1:0]     in_instr,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OP_BITS-1:0]  out_op,
   output logic [RBITS-1:0]    out_wsel,
   output logic [RBITS-1:0]    out_asel,
   output logic [RBITS-1:0]    out_bsel,
   output logic [IMM5_W-1:0]   out_imm5,
   output logic [IMM8_W-1:0]   out_imm8,
   output logic [IMM11_W-1:0]  out_imm11,
   output logic                out_cond_update,
   output logic                out_mem_rd,
   output logic                out_mem_wr,
   output logic                out_reg_wr,
   input  logic                wb_valid,
   input  logic [RBITS-1:0]    wb_sel,
   input  logic                flush
`ifdef DECODE_ISSUE_STATS_EN
   ,
   output logic [15:0]         stall_cnt,
   output logic [15:0]         issue_cnt
`endif
);

   localparam int unsigned NREGS = 2**RBITS;

   logic                r_held;
   logic [OP_BITS-1:0]  r_op;
   logic [RBITS-1:0]    r_wsel, r_asel, r_bsel;
   logic [IMM5_W-1:0]   r_imm5;
   logic [IMM8_W-1:0]   r_imm8;
   logic [IMM11_W-1:0]  r_imm11;
   ctrl_t               r_ctrl;

   logic [OP_BITS-1:0]  w_op;
   ctrl_t               w_ctrl;
   logic [NREGS-1:0]    w_pend;
   logic                w_hazard;
   logic                w_out_valid;
   logic                w_issue;
   logic                w_in_ready;
   logic                w_capture;

   assign w_op   = in_instr[BITS-1 -: OP_BITS];
   assign w_ctrl = decode_ctrl(w_op);

   // Source selects are checked regardless of opcode
   assign w_hazard    = r_held & (w_pend[r_asel] | w_pend[r_bsel] |
                                  (r_ctrl.reg_wr & w_pend[r_wsel]));
   assign w_out_valid = r_held & !w_hazard & !flush;
   assign w_issue     = w_out_valid & out_ready;
   assign w_in_ready  = !flush & (!r_held | w_issue);
   assign w_capture   = in_valid & w_in_ready;

   reg_scoreboard #(
      .RBITS (RBITS),
      .NREGS (NREGS)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .i_set     (w_issue & r_ctrl.reg_wr),
      .i_set_sel (r_wsel),
      .i_clr     (wb_valid),
      .i_clr_sel (wb_sel),
      .o_pend    (w_pend)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_held  <= 1'b0;
         r_op    <= '0;
         r_wsel  <= '0;
         r_asel  <= '0;
         r_bsel  <= '0;
         r_imm5  <= '0;
         r_imm8  <= '0;
         r_imm11 <= '0;
         r_ctrl  <= '0;
      end else begin
         if (flush)          r_held <= 1'b0;
         else if (w_capture) r_held <= 1'b1;
         else if (w_issue)   r_held <= 1'b0;
         if (w_capture) begin
            r_op    <= w_op;
            r_wsel  <= in_instr[WSEL_LSB +: RBITS];
            r_asel  <= in_instr[ASEL_LSB +: RBITS];
            r_bsel  <= in_instr[BSEL_LSB +: RBITS];
            r_imm5  <= in_instr[IMM5_W-1:0];
            r_imm8  <= in_instr[IMM8_W-1:0];
            r_imm11 <= in_instr[IMM11_W-1:0];
            r_ctrl  <= w_ctrl;
         end
      end
   end

   assign in_ready        = w_in_ready;
   assign out_valid       = w_out_valid;
   assign out_op          = r_op;
   assign out_wsel        = r_wsel;
   assign out_asel        = r_asel;
   assign out_bsel        = r_bsel;
   assign out_imm5        = r_imm5;
   assign out_imm8        = r_imm8;
   assign out_imm11       = r_imm11;
   assign out_cond_update = r_ctrl.cond_update;
   assign out_mem_rd      = r_ctrl.mem_rd;
   assign out_mem_wr      = r_ctrl.mem_wr;
   assign out_reg_wr      = r_ctrl.reg_wr;

`ifdef DECODE_ISSUE_STATS_EN
   logic [15:0] r_stall_cnt;
   logic [15:0] r_issue_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_issue_cnt <= '0;
      end else begin
         if (w_hazard && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
         if (w_issue) r_issue_cnt <= r_issue_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign issue_cnt = r_issue_cnt;
`endif

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage: directed scenarios then random traffic.
module tb_decode_issue_stage;

   typedef struct packed {
      logic [4:0]  op;
      logic [2:0]  w, a, b;
      logic [4:0]  i5;
      logic [7:0]  i8;
      logic [10:0] i11;
      logic        cu, mr, mw, rw;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, out_ready = 1'b0, wb_valid = 1'b0, flush = 1'b0;
   logic [15:0] in_instr = '0;
   logic [2:0]  wb_sel = '0;
   logic        in_ready, out_valid;
   logic [4:0]  out_op, out_imm5;
   logic [2:0]  out_wsel, out_asel, out_bsel;
   logic [7:0]  out_imm8;
   logic [10:0] out_imm11;
   logic        out_cond_update, out_mem_rd, out_mem_wr, out_reg_wr;
`ifdef DECODE_ISSUE_STATS_EN
   logic [15:0] stall_cnt, issue_cnt;
`endif

   int   total = 0;
   int   bad   = 0;
   int   n_iss = 0;
   exp_t q[$];
   // Reference state: held entry and the set of registers with writes in flight
   bit   m_held = 0;
   exp_t m_e    = '0;
   bit   m_pend[8];

   decode_issue_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_wsel(out_wsel),
      .out_asel(out_asel), .out_bsel(out_bsel), .out_imm5(out_imm5), .out_imm8(out_imm8),
      .out_imm11(out_imm11), .out_cond_update(out_cond_update), .out_mem_rd(out_mem_rd),
      .out_mem_wr(out_mem_wr), .out_reg_wr(out_reg_wr), .wb_valid(wb_valid),
      .wb_sel(wb_sel), .flush(flush)
`ifdef DECODE_ISSUE_STATS_EN
      , .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic exp_t exp_of(input logic [15:0] ins);
      exp_t r;
      bit A, B, C, D, E;
      r.op = ins[15:11];
      A = r.op[4]; B = r.op[3]; C = r.op[2]; D = r.op[1]; E = r.op[0];
      r.w   = ins[10:8];
      r.a   = ins[7:5];
      r.b   = ins[4:2];
      r.i5  = ins[4:0];
      r.i8  = ins[7:0];
      r.i11 = ins[10:0];
      r.cu  = (!B && !D && E) || (!B && !C && !E) || (!A && !C && !D && E) ||
              (!A && B && C && !D && !E);
      r.mr  = !A && C && D && E;
      r.mw  = (!A && !C && D && E) || (A && B && C && D && E);
      r.rw  = (!A && !C && !D) || (!A && B && C) || (!A && D && !E) || (!B && C && D) ||
              (A && !B && !C) || (A && !B && !D && !E);
      return r;
   endfunction

   function automatic bit exp_valid();
      bit busy[8];
      busy = m_pend;
      if (wb_valid) busy[wb_sel] = 0;
      if (!m_held || flush) return 0;
      return !(busy[m_e.a] || busy[m_e.b] || (m_e.rw && busy[m_e.w]));
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic step(input bit iv, input logic [15:0] ins, input bit ord, input bit wbv,
                       input logic [2:0] wbs, input bit fl);
      @(posedge clk);
      #1;
      in_valid = iv; in_instr = ins; out_ready = ord; wb_valid = wbv; wb_sel = wbs; flush = fl;
   endtask

   // Reference model advances on each accepted edge
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_held = 0;
         foreach (m_pend[i]) m_pend[i] = 0;
         q.delete();
      end else begin
         bit v, rdy;
         v   = exp_valid();
         rdy = !flush && (!m_held || (v && out_ready));
         if (wb_valid) m_pend[wb_sel] = 0;
         if (v && out_ready && m_e.rw) m_pend[m_e.w] = 1;
         if (flush) begin
            if (m_held && q.size() > 0) void'(q.pop_back());
            m_held = 0;
         end else if (in_valid && rdy) begin
            m_e    = exp_of(in_instr);
            m_held = 1;
            q.push_back(m_e);
         end else if (v && out_ready) begin
            m_held = 0;
         end
      end
   end

   // Monitor: handshake checks every cycle, field checks on each issue
   always @(negedge clk) begin
      if (!rst) begin
         bit   v;
         exp_t e;
         v = exp_valid();
         chk("out_valid", 64'(out_valid), 64'(v));
         chk("in_ready", 64'(in_ready), 64'(!flush && (!m_held || (v && out_ready))));
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL issue_unexpected actual=issue required=none at %0t", $time);
            end else begin
               e = q.pop_front();
               chk("issue_fields", 64'({out_op, out_wsel, out_asel, out_bsel, out_imm5,
                   out_imm8, out_imm11, out_cond_update, out_mem_rd, out_mem_wr, out_reg_wr}),
                   64'(e));
               n_iss++;
            end
         end
      end
   end

   initial begin
      foreach (m_pend[i]) m_pend[i] = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_fields", 64'({out_op, out_wsel, out_imm11, out_reg_wr}), 64'd0);

      // Basic decode of a load-like op
      step(1, 16'h3A4C, 0, 0, 0, 0);
      step(0, 16'h0000, 0, 0, 0, 0);
      @(negedge clk);
      chk("d1_valid", 64'(out_valid), 64'd1);
      chk("d1_ctrl", 64'({out_cond_update, out_mem_rd, out_mem_wr, out_reg_wr}), 64'b0101);
      chk("d1_sels", 64'({out_wsel, out_asel, out_bsel}), 64'({3'd2, 3'd2, 3'd3}));

      // RAW hold on r2, released by same-cycle writeback
      step(1, 16'h0040, 1, 0, 0, 0);
      step(0, 16'h0000, 1, 0, 0, 0);
      @(negedge clk);
      chk("raw_stall_valid", 64'(out_valid), 64'd0);
      chk("raw_stall_ready", 64'(in_ready), 64'd0);
      step(0, 16'h0000, 1, 1, 3'd2, 0);
      @(negedge clk);
      chk("raw_wb_release", 64'(out_valid), 64'd1);
      step(0, 16'h0000, 0, 1, 3'd0, 0);

      // All-ones opcode: store-like, no register write
      step(1, 16'hFFFF, 0, 0, 0, 0);
      step(0, 16'h0000, 0, 0, 0, 0);
      @(negedge clk);
      chk("ffff_ctrl", 64'({out_cond_update, out_mem_rd, out_mem_wr, out_reg_wr}), 64'b0010);
      step(1, 16'h3FFF, 1, 0, 0, 0);
      step(0, 16'h0000, 0, 0, 0, 0);
      @(negedge clk);
      chk("ffff_no_pend", 64'(out_valid), 64'd1);
      step(0, 16'h0000, 1, 0, 0, 0);
      step(0, 16'h0000, 1, 1, 3'd7, 0);

      // Back-to-back throughput
      for (int i = 0; i < 9; i++) begin
         logic [10:0] imm;
         imm = 11'(i * 13 + 1);
         step(i < 8, {5'b11111, imm}, 1, 0, 0, 0);
         if (i > 0) begin
            @(negedge clk);
            chk("b2b_valid", 64'(out_valid), 64'd1);
            chk("b2b_order", 64'(out_imm11), 64'(11'((i - 1) * 13 + 1)));
         end
      end

      // Flush drops the held entry and blocks capture
      step(1, 16'h3A4C, 0, 0, 0, 0);
      step(1, 16'h0040, 0, 0, 0, 1);
      @(negedge clk);
      chk("flush_in_ready", 64'(in_ready), 64'd0);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      step(0, 16'h0000, 1, 0, 0, 0);
      @(negedge clk);
      chk("flush_dropped", 64'(out_valid), 64'd0);

      // Async reset while stalled with r2 pending
      step(1, 16'h3A4C, 1, 0, 0, 0);
      step(1, 16'h0040, 1, 0, 0, 0);
      step(0, 16'h0000, 1, 0, 0, 0);
      @(negedge clk);
      chk("pre_rst_stall", 64'(out_valid), 64'd0);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
`ifdef DECODE_ISSUE_STATS_EN
      chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
      in_valid = 0; out_ready = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      n_iss = 0;
      step(1, 16'h0040, 0, 0, 0, 0);
      step(0, 16'h0000, 0, 0, 0, 0);
      @(negedge clk);
      chk("arst_sb_clear", 64'(out_valid), 64'd1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 4) != 0, 16'($urandom), ($urandom % 4) != 0, ($urandom % 3) == 0,
              3'($urandom), ($urandom % 32) == 0);
      end
      step(0, 16'h0000, 1, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 16'h0000, 1, 1, 3'(i), 0);
      step(0, 16'h0000, 1, 0, 0, 0);
      @(negedge clk);
`ifdef DECODE_ISSUE_STATS_EN
      chk("issue_cnt", 64'(issue_cnt), 64'(16'(n_iss)));
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
